// File: rtl/demux_1_4_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : demux_1_4_seq_if                                             |
// | Description : Producer-side and four consumer-side handshake bundle for    |
// |               demux_1_4_seq. Cnt0..Cnt3 exist only with DEMUX_1_4_CNT_EN.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface demux_1_4_seq_if #(
    parameter int W = 8
`ifdef DEMUX_1_4_CNT_EN
    , parameter int CNT_W = 8
`endif
);
    logic [W-1:0]     In;
    logic             In_valid;
    logic             In_ready;
    logic             Sel1;
    logic             Sel0;
    logic             Rr_en;

    logic [W-1:0]     Out0;
    logic [W-1:0]     Out1;
    logic [W-1:0]     Out2;
    logic [W-1:0]     Out3;
    logic             Out0_valid;
    logic             Out1_valid;
    logic             Out2_valid;
    logic             Out3_valid;
    logic             Out0_ready;
    logic             Out1_ready;
    logic             Out2_ready;
    logic             Out3_ready;

`ifdef DEMUX_1_4_CNT_EN
    logic [CNT_W-1:0] Cnt0;
    logic [CNT_W-1:0] Cnt1;
    logic [CNT_W-1:0] Cnt2;
    logic [CNT_W-1:0] Cnt3;
`endif

    // Master drives the producer and consumer-ready sides (system / bench).
    modport master (
        output In, In_valid, Sel1, Sel0, Rr_en,
        output Out0_ready, Out1_ready, Out2_ready, Out3_ready,
        input  In_ready,
        input  Out0, Out1, Out2, Out3,
        input  Out0_valid, Out1_valid, Out2_valid, Out3_valid
`ifdef DEMUX_1_4_CNT_EN
        , input Cnt0, Cnt1, Cnt2, Cnt3
`endif
    );

    modport slave (
        input  In, In_valid, Sel1, Sel0, Rr_en,
        input  Out0_ready, Out1_ready, Out2_ready, Out3_ready,
        output In_ready,
        output Out0, Out1, Out2, Out3,
        output Out0_valid, Out1_valid, Out2_valid, Out3_valid
`ifdef DEMUX_1_4_CNT_EN
        , output Cnt0, Cnt1, Cnt2, Cnt3
`endif
    );
endinterface
`default_nettype wire

// File: rtl/demux_1_4_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : demux_1_4_seq                                                |
// | Description : Registered 1-to-4 demultiplexer, one 1-deep holding register |
// |               per channel, select or strict round-robin routing.           |
// |               Optional delivery counters: define DEMUX_1_4_CNT_EN.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module demux_1_4_seq #(
    parameter int W = 8
`ifdef DEMUX_1_4_CNT_EN
    , parameter int CNT_W = 8
`endif
) (
    input  wire logic          Clk,
    input  wire logic          Rst_n,
    demux_1_4_seq_if.slave     bus
);

    localparam int c_NCH = 4;

    logic [W-1:0]     r_data [c_NCH];
    logic [c_NCH-1:0] r_valid;
    logic [1:0]       r_rr_ptr;

    logic [c_NCH-1:0] w_out_ready;
    logic [c_NCH-1:0] w_load;
    logic [c_NCH-1:0] w_deliver;
    logic [1:0]       w_dest;
    logic             w_in_ready;
    logic             w_accept;

    assign w_out_ready = {bus.Out3_ready, bus.Out2_ready, bus.Out1_ready, bus.Out0_ready};

    always_comb begin
        w_dest     = bus.Rr_en ? r_rr_ptr : {bus.Sel1, bus.Sel0};
        // Ready is gated by Rst_n so the producer sees a stall throughout reset.
        w_in_ready = Rst_n && (!r_valid[w_dest] || w_out_ready[w_dest]);
        w_accept   = bus.In_valid && w_in_ready;
        w_deliver  = r_valid & w_out_ready;
    end

    // Strict round-robin: the pointer only advances on an actual accept.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_rr_ptr <= 2'd0;
        end else if (w_accept && bus.Rr_en) begin
            r_rr_ptr <= r_rr_ptr + 2'd1;
        end
    end

    generate
        for (genvar n = 0; n < c_NCH; n++) begin : g_chan
            assign w_load[n] = w_accept && (w_dest == 2'(n));

            // A load takes priority so a same-cycle deliver+refill keeps valid high.
            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    r_data[n]  <= '0;
                    r_valid[n] <= 1'b0;
                end else if (w_load[n]) begin
                    r_data[n]  <= bus.In;
                    r_valid[n] <= 1'b1;
                end else if (w_deliver[n]) begin
                    r_valid[n] <= 1'b0;
                end
            end
        end
    endgenerate

    assign bus.In_ready   = w_in_ready;
    assign bus.Out0       = r_data[0];
    assign bus.Out1       = r_data[1];
    assign bus.Out2       = r_data[2];
    assign bus.Out3       = r_data[3];
    assign bus.Out0_valid = r_valid[0];
    assign bus.Out1_valid = r_valid[1];
    assign bus.Out2_valid = r_valid[2];
    assign bus.Out3_valid = r_valid[3];

`ifdef DEMUX_1_4_CNT_EN
    logic [CNT_W-1:0] r_cnt [c_NCH];

    generate
        for (genvar n = 0; n < c_NCH; n++) begin : g_cnt
            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    r_cnt[n] <= '0;
                end else if (w_deliver[n]) begin
                    r_cnt[n] <= r_cnt[n] + 1'b1;
                end
            end
        end
    endgenerate

    assign bus.Cnt0 = r_cnt[0];
    assign bus.Cnt1 = r_cnt[1];
    assign bus.Cnt2 = r_cnt[2];
    assign bus.Cnt3 = r_cnt[3];
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux_1_4_seq.sv
`default_nettype none
// Testbench for demux_1_4_seq: directed vector table, hand-written reset and
// counter sequences, and randomized traffic against a slot-level reference model.
module tb_demux_1_4_seq;

    logic Clk;
    logic Rst_n;
    int   n_checks;
    int   n_fail;

    demux_1_4_seq_if #(.W(8)) bus ();

    demux_1_4_seq #(.W(8)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic       rr;
        logic [1:0] sel;
        logic [7:0] din;
        logic       vld;
        logic [3:0] rdy;
        logic       exp_rdy;
        logic [3:0] exp_v;
        int         ch;
        logic [7:0] exp_d;
    } vec_t;

    vec_t tbl [20];

    // reference model state
    bit       m_v [4];
    int       m_d [4];
    int       m_ptr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] vmask();
        return {bus.Out3_valid, bus.Out2_valid, bus.Out1_valid, bus.Out0_valid};
    endfunction

    function automatic logic [7:0] odata(input int ch);
        case (ch)
            0:       return bus.Out0;
            1:       return bus.Out1;
            2:       return bus.Out2;
            default: return bus.Out3;
        endcase
    endfunction

    task automatic drive(input logic rr, input logic [1:0] sel, input logic [7:0] din,
                         input logic vld, input logic [3:0] rdy);
        bus.Rr_en      = rr;
        bus.Sel1       = sel[1];
        bus.Sel0       = sel[0];
        bus.In         = din;
        bus.In_valid   = vld;
        bus.Out0_ready = rdy[0];
        bus.Out1_ready = rdy[1];
        bus.Out2_ready = rdy[2];
        bus.Out3_ready = rdy[3];
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 2'd0, 8'h00, 1'b0, 4'h0);
        Rst_n = 1'b0;
        #12;
        @(negedge Clk);
        Rst_n = 1'b1;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        Rst_n    = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 1'b0, 4'h0);

        // Sequence: select routing, stall-and-refill, round-robin wrap, blocked RR with toggling
        tbl[0]  = '{1'b0, 2'd1, 8'hA5, 1'b1, 4'b0010, 1'b1, 4'b0010, 1, 8'hA5};
        tbl[1]  = '{1'b0, 2'd0, 8'h00, 1'b0, 4'b0010, 1'b1, 4'b0000, 1, 8'hA5};
        tbl[2]  = '{1'b0, 2'd3, 8'h11, 1'b1, 4'b0000, 1'b1, 4'b1000, 3, 8'h11};
        tbl[3]  = '{1'b0, 2'd3, 8'h22, 1'b1, 4'b0000, 1'b0, 4'b1000, 3, 8'h11};
        tbl[4]  = '{1'b0, 2'd3, 8'h22, 1'b1, 4'b0000, 1'b0, 4'b1000, 3, 8'h11};
        tbl[5]  = '{1'b0, 2'd3, 8'h22, 1'b1, 4'b1000, 1'b1, 4'b1000, 3, 8'h22};
        tbl[6]  = '{1'b0, 2'd3, 8'h00, 1'b0, 4'b1000, 1'b1, 4'b0000, 3, 8'h22};
        tbl[7]  = '{1'b1, 2'd0, 8'h10, 1'b1, 4'b1111, 1'b1, 4'b0001, 0, 8'h10};
        tbl[8]  = '{1'b1, 2'd0, 8'h11, 1'b1, 4'b1111, 1'b1, 4'b0010, 1, 8'h11};
        tbl[9]  = '{1'b1, 2'd0, 8'h12, 1'b1, 4'b1111, 1'b1, 4'b0100, 2, 8'h12};
        tbl[10] = '{1'b1, 2'd0, 8'h13, 1'b1, 4'b1111, 1'b1, 4'b1000, 3, 8'h13};
        tbl[11] = '{1'b1, 2'd0, 8'h14, 1'b1, 4'b1111, 1'b1, 4'b0001, 0, 8'h14};
        tbl[12] = '{1'b1, 2'd0, 8'h15, 1'b1, 4'b1111, 1'b1, 4'b0010, 1, 8'h15};
        tbl[13] = '{1'b1, 2'd0, 8'h16, 1'b1, 4'b0000, 1'b1, 4'b0110, 2, 8'h16};
        tbl[14] = '{1'b1, 2'd0, 8'h17, 1'b1, 4'b0000, 1'b1, 4'b1110, 3, 8'h17};
        tbl[15] = '{1'b1, 2'd0, 8'h18, 1'b1, 4'b0000, 1'b1, 4'b1111, 0, 8'h18};
        tbl[16] = '{1'b1, 2'd0, 8'h19, 1'b1, 4'b0000, 1'b0, 4'b1111, 1, 8'h15};
        tbl[17] = '{1'b0, 2'd0, 8'h19, 1'b1, 4'b0001, 1'b1, 4'b1111, 0, 8'h19};
        tbl[18] = '{1'b1, 2'd0, 8'h1A, 1'b1, 4'b0010, 1'b1, 4'b1111, 1, 8'h1A};
        tbl[19] = '{1'b0, 2'd0, 8'h00, 1'b0, 4'b1111, 1'b1, 4'b0000, 1, 8'h1A};

        // Reset state, sampled while reset is still asserted and just after release
        #3;
        chk("rst_in_ready_low", {31'd0, bus.In_ready}, 32'd0);
        chk("rst_valid", {28'd0, vmask()}, 32'd0);
        do_reset();
        chk("rst_in_ready_high", {31'd0, bus.In_ready}, 32'd1);
        chk("rst_out_data", {bus.Out3, bus.Out2, bus.Out1, bus.Out0}, 32'd0);

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].rr, tbl[i].sel, tbl[i].din, tbl[i].vld, tbl[i].rdy);
            @(negedge Clk);
            chk($sformatf("vec%0d_in_ready", i), {31'd0, bus.In_ready}, {31'd0, tbl[i].exp_rdy});
            tick();
            chk($sformatf("vec%0d_valid", i), {28'd0, vmask()}, {28'd0, tbl[i].exp_v});
            chk($sformatf("vec%0d_data", i), {24'd0, odata(tbl[i].ch)}, {24'd0, tbl[i].exp_d});
        end

        // Randomized traffic; the table leaves all channels empty with the pointer at 2
        for (int c = 0; c < 4; c++) begin
            m_v[c] = 1'b0;
            m_d[c] = 0;
        end
        m_ptr = 2;
        for (int k = 0; k < 400; k++) begin
            logic       rr;
            logic [1:0] sel;
            logic [7:0] din;
            logic       vld;
            logic [3:0] rdy;
            int         d;
            bit         acc;
            rr  = ($urandom_range(0, 2) != 0);
            sel = 2'($urandom_range(0, 3));
            din = 8'($urandom_range(0, 255));
            vld = ($urandom_range(0, 3) != 0);
            rdy = 4'($urandom_range(0, 15));
            drive(rr, sel, din, vld, rdy);
            @(negedge Clk);
            d   = rr ? m_ptr : int'(sel);
            acc = vld && (!m_v[d] || rdy[d]);
            chk("rand_in_ready", {31'd0, bus.In_ready}, {31'd0, (!m_v[d] || rdy[d])});
            for (int c = 0; c < 4; c++) begin
                chk("rand_valid", {31'd0, vmask()[c]}, {31'd0, m_v[c]});
                if (m_v[c])
                    chk("rand_data", {24'd0, odata(c)}, m_d[c]);
            end
            for (int c = 0; c < 4; c++) begin
                if (acc && d == c) begin
                    m_v[c] = 1'b1;
                    m_d[c] = int'(din);
                end else if (m_v[c] && rdy[c]) begin
                    m_v[c] = 1'b0;
                end
            end
            if (acc && rr)
                m_ptr = (m_ptr + 1) % 4;
            tick();
        end

        // Mid-stream reset with Out2 holding a word
        drive(1'b0, 2'd0, 8'h00, 1'b0, 4'hF);
        tick();
        drive(1'b0, 2'd2, 8'h77, 1'b1, 4'h0);
        tick();
        chk("pre_rst_out2_valid", {28'd0, vmask()}, 32'h4);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {28'd0, vmask()}, 32'd0);
        chk("mid_rst_data", {bus.Out3, bus.Out2, bus.Out1, bus.Out0}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, bus.In_ready}, 32'd0);
        drive(1'b0, 2'd0, 8'h00, 1'b0, 4'h0);
        @(negedge Clk);
        Rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", {31'd0, bus.In_ready}, 32'd1);
        chk("post_rst_valid", {28'd0, vmask()}, 32'd0);
        drive(1'b1, 2'd3, 8'h5A, 1'b1, 4'h0);
        tick();
        chk("post_rst_rr_ptr0", {28'd0, vmask()}, 32'h1);
        chk("post_rst_rr_data", {24'd0, bus.Out0}, 32'h5A);
        drive(1'b1, 2'd3, 8'h5B, 1'b1, 4'h0);
        tick();
        chk("post_rst_rr_ptr1", {28'd0, vmask()}, 32'h3);

`ifdef DEMUX_1_4_CNT_EN
        // 257 deliveries on channel 0 wrap an 8-bit counter to 1
        do_reset();
        drive(1'b0, 2'd0, 8'h01, 1'b1, 4'hF);
        repeat (257) tick();
        drive(1'b0, 2'd0, 8'h00, 1'b0, 4'hF);
        tick();
        drive(1'b0, 2'd0, 8'h00, 1'b0, 4'h0);
        tick();
        chk("cnt0_wrap", {24'd0, bus.Cnt0}, 32'd1);
        chk("cnt_others", {8'd0, bus.Cnt3, bus.Cnt2, bus.Cnt1}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
